// File: rtl/trace_buffer_pkg.sv
// Shared types and width helpers for the multi-channel trace buffer.
// Optional feature macro: TB_TIMESTAMP_EN (adds a per-entry timestamp).
package trace_buffer_pkg;

`ifdef TB_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } tb_state_e;

  localparam int unsigned DROP_MAX = 255;

  function automatic int unsigned tb_chw(input int unsigned ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

  function automatic int unsigned tb_width(input int unsigned fpay,
                                           input int unsigned ch_num,
                                           input int unsigned ts_w);
    return (TS_EN ? ts_w : 0) + tb_chw(ch_num) + fpay;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port BRAM, one write port and one registered read port.
// SSA_EN = "YES" forwards same-cycle same-address write data to the read port.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter string       SSA_EN     = "NO"
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam bit SSA = (SSA_EN == "YES");

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Registered read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rd_en) begin
      if (SSA && wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
      else                                      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/tb_rr_arbiter.sv
// Rotating-priority arbiter: highest priority is the channel after the last winner.
module tb_rr_arbiter #(
  parameter int unsigned  N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int unsigned   cand;
  logic [IW-1:0] cidx;

  // Scan requests starting at the priority pointer, first hit wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= N) cand = cand - N;
      cidx = IW'(cand);
      if (!found && req_i[cidx]) begin
        found         = 1'b1;
        grant_o[cidx] = 1'b1;
        idx_o         = cidx;
      end
    end
  end

  // Pointer moves past the winner only when the grant is consumed
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) ptr_d = (32'(idx_o) == N - 1) ? '0 : idx_o + IW'(1);
  end

  // Priority pointer register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/trace_buffer_mc.sv
// Multi-channel debug trace buffer: round-robin merge into a circular BRAM
// with pre-trigger window, programmable post-trigger count, oldest-first drain.
// Optional feature macro: TB_TIMESTAMP_EN (timestamp prepended to each entry).
module trace_buffer_mc
  import trace_buffer_pkg::*;
#(
  parameter int unsigned  Fpay   = 32,
  parameter int unsigned  CH_NUM = 4,
  parameter int unsigned  TB_AW  = 9,
  parameter int unsigned  TS_W   = 16,
  localparam int unsigned CHW    = tb_chw(CH_NUM),
  localparam int unsigned TB_W   = tb_width(Fpay, CH_NUM, TS_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CH_NUM*Fpay-1:0] trace,
  input  logic [CH_NUM-1:0]      trace_vld,
  input  logic                   arm,
  input  logic                   trigger,
  input  logic [TB_AW:0]         post_len,
  input  logic                   rd,
  output logic [TB_W-1:0]        dout,
  output logic                   dout_vld,
  output logic [TB_AW:0]         level,
  output logic [1:0]             state,
  output logic                   trig_seen,
  output logic [7:0]             drop_cnt
);

  localparam logic [TB_AW:0] DEPTH = {1'b1, {TB_AW{1'b0}}};

  tb_state_e        state_q, state_d;
  logic [TB_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TB_AW:0]   level_q, level_d, post_cnt_q, post_cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             trig_q, trig_d, dout_vld_q, dout_vld_d;

  logic [CH_NUM-1:0] grant;
  logic [CHW-1:0]    win_idx;
  logic [Fpay-1:0]   win_pay;
  logic [TB_W-1:0]   entry;
  logic              wr_en, rd_en;
  int unsigned       n_vld, drop_sum;

  tb_rr_arbiter #(.N(CH_NUM)) u_arb (
    .clk_i   (clk),
    .rst_n_i (reset),
    .req_i   (trace_vld),
    .adv_i   (wr_en),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  // Winner payload select and valid popcount
  always_comb begin
    win_pay = '0;
    n_vld   = 0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (grant[i])     win_pay = win_pay | trace[i*Fpay +: Fpay];
      if (trace_vld[i]) n_vld   = n_vld + 1;
    end
  end

`ifdef TB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running timestamp, stored with each entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  assign entry = {ts_q, win_idx, win_pay};
`else
  assign entry = {win_idx, win_pay};
`endif

  // Capture/trigger/drain control; arm overrides everything else
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    post_cnt_d = post_cnt_q;
    drop_d     = drop_q;
    trig_d     = trig_q;
    dout_vld_d = 1'b0;
    rd_en      = 1'b0;
    drop_sum   = 0;
    wr_en      = !arm && (|trace_vld) && ((state_q == ARMED) || (state_q == POST));

    if (arm) begin
      state_d    = ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      post_cnt_d = '0;
      drop_d     = '0;
      trig_d     = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + TB_AW'(1);
        if (level_q != DEPTH) level_d = level_q + 1'b1;
        drop_sum = 32'(drop_q) + n_vld - 1;
        drop_d   = (drop_sum > DROP_MAX) ? 8'(DROP_MAX) : 8'(drop_sum);
      end
      // The DONE-entry rd_ptr uses next-state wr_ptr/level so a same-cycle
      // write is already accounted for when locating the oldest entry.
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (trigger) begin
            trig_d = 1'b1;
            if (post_len == '0) begin
              state_d  = DONE;
              rd_ptr_d = wr_ptr_d - level_d[TB_AW-1:0];
            end else begin
              state_d    = POST;
              post_cnt_d = (post_len > DEPTH) ? DEPTH : post_len;
            end
          end
        end
        POST: begin
          if (wr_en) begin
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == 1) begin
              state_d  = DONE;
              rd_ptr_d = wr_ptr_d - level_d[TB_AW-1:0];
            end
          end
        end
        DONE: begin
          if (rd && (level_q != '0)) begin
            rd_en      = 1'b1;
            rd_ptr_d   = rd_ptr_q + TB_AW'(1);
            level_d    = level_q - 1'b1;
            dout_vld_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      post_cnt_q <= '0;
      drop_q     <= '0;
      trig_q     <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      post_cnt_q <= post_cnt_d;
      drop_q     <= drop_d;
      trig_q     <= trig_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (TB_W),
    .ADDR_WIDTH (TB_AW),
    .SSA_EN     ("NO")
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (entry),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (dout)
  );

  assign dout_vld  = dout_vld_q;
  assign level     = level_q;
  assign state     = state_q;
  assign trig_seen = trig_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_trace_buffer_mc.sv
// Self-checking bench for trace_buffer_mc against a queue-based reference model.
// Timestamp checks compile in when TB_TIMESTAMP_EN is defined.
module tb_trace_buffer_mc;
  import trace_buffer_pkg::*;

  localparam int unsigned FPAY  = 32;
  localparam int unsigned CHN   = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned TSW   = 16;
  localparam int unsigned CHW_L = tb_chw(CHN);
  localparam int unsigned TBW   = tb_width(FPAY, CHN, TSW);
  localparam int unsigned DEPTH = 1 << AW;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CHN*FPAY-1:0]   trace;
  logic [CHN-1:0]        trace_vld;
  logic                  arm, trigger, rd;
  logic [AW:0]           post_len;
  logic [TBW-1:0]        dout;
  logic                  dout_vld;
  logic [AW:0]           level;
  logic [1:0]            state;
  logic                  trig_seen;
  logic [7:0]            drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: a bounded queue of stored entries, oldest at the front
  logic [TBW-1:0] mq[$];
  int             m_state, m_drop, m_post, m_last;
  bit             m_trig, m_vld;
  logic [TBW-1:0] m_dout;
  int unsigned    m_ts;

  trace_buffer_mc #(.Fpay(FPAY), .CH_NUM(CHN), .TB_AW(AW), .TS_W(TSW)) dut (
    .clk       (clk),
    .reset     (reset),
    .trace     (trace),
    .trace_vld (trace_vld),
    .arm       (arm),
    .trigger   (trigger),
    .post_len  (post_len),
    .rd        (rd),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .level     (level),
    .state     (state),
    .trig_seen (trig_seen),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [TBW-1:0] mk_entry(input int unsigned ts, input int ch,
                                              input logic [FPAY-1:0] pay);
    logic [TBW-1:0] e, t, c;
    t = TBW'(ts % (1 << TSW));
    c = TBW'(ch);
    e = TBW'(pay) | (c << FPAY) | (t << (FPAY + CHW_L));
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_drop = 0; m_post = 0; m_last = CHN - 1;
    m_trig = 0; m_vld = 0; m_ts = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit
  task automatic cycle(input logic [CHN-1:0] v, input logic [CHN*FPAY-1:0] d,
                       input logic a, input logic t, input logic r,
                       input logic [AW:0] pl);
    int w, n;
    bit wr;
    trace_vld = v; trace = d; arm = a; trigger = t; rd = r; post_len = pl;
    @(posedge clk);
    m_vld = 0;
    if (a) begin
      mq.delete();
      m_state = 1; m_drop = 0; m_post = 0; m_trig = 0;
    end else begin
      wr = ((m_state == 1) || (m_state == 2)) && (v != '0);
      if (wr) begin
        n = $countones(v);
        w = m_last;
        do w = (w + 1) % CHN; while (!v[w]);
        mq.push_back(mk_entry(m_ts, w, d[w*FPAY +: FPAY]));
        if (mq.size() > DEPTH) void'(mq.pop_front());
        m_last = w;
        m_drop = (m_drop + n - 1 > 255) ? 255 : m_drop + n - 1;
      end
      case (m_state)
        1: if (t) begin
             m_trig = 1;
             if (pl == 0) m_state = 3;
             else begin
               m_state = 2;
               m_post  = (int'(pl) > DEPTH) ? DEPTH : int'(pl);
             end
           end
        2: if (wr) begin
             m_post--;
             if (m_post == 0) m_state = 3;
           end
        3: if (r && mq.size() > 0) begin
             m_dout = mq.pop_front();
             m_vld  = 1;
           end
        default: ;
      endcase
    end
    m_ts++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    trace = '0; trace_vld = '0; arm = 0; trigger = 0; rd = 0; post_len = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [CHN*FPAY-1:0] d;
    apply_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (level !== '0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", dout_vld); end
    checks++; if (trig_seen !== 1'b0) begin errors++; $display("FAIL rst_trig got %b exp 0", trig_seen); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    // Reach POST with stored entries, then assert reset asynchronously
    cycle('0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 6; k++) begin
      d = '0; d[FPAY-1:0] = FPAY'(k);
      cycle(4'b0011, d, 1'b0, 1'b0, 1'b0, '0);
    end
    cycle('0, '0, 1'b0, 1'b1, 1'b0, 5'd10);
    cycle(4'b0001, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(4'b0001, '0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_rst_post got %0d exp 2", state); end
    checks++; if (level !== 5'(mq.size())) begin errors++; $display("FAIL pre_rst_level got %0d exp %0d", level, mq.size()); end
    #2 reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state got %0d exp 0", state); end
    checks++; if (level !== '0) begin errors++; $display("FAIL async_level got %0d exp 0", level); end
    checks++; if (trig_seen !== 1'b0) begin errors++; $display("FAIL async_trig got %b exp 0", trig_seen); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL async_drop got %0d exp 0", drop_cnt); end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      cycle('0, '0, 1'b0, 1'b0, 1'b1, '0);
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL rd_after_rst vld got %b exp 0", dout_vld); end
      checks++; if (level !== '0) begin errors++; $display("FAIL rd_after_rst level got %0d exp 0", level); end
    end
  endtask

  task automatic test_single_channel();
    logic [CHN*FPAY-1:0] d;
    cycle('0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      d = '0; d[2*FPAY +: FPAY] = FPAY'(32'hA0 + k);
      cycle(4'b0100, d, 1'b0, 1'b0, 1'b0, '0);
    end
    cycle('0, '0, 1'b0, 1'b1, 1'b0, 5'd3);
    checks++; if (trig_seen !== 1'b1) begin errors++; $display("FAIL sc_trig got %b exp 1", trig_seen); end
    for (int k = 5; k < 8; k++) begin
      d = '0; d[2*FPAY +: FPAY] = FPAY'(32'hA0 + k);
      cycle(4'b0100, d, 1'b0, 1'b0, 1'b0, '0);
    end
    idle(1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL sc_state got %0d exp 3", state); end
    checks++; if (level !== 5'd8) begin errors++; $display("FAIL sc_level got %0d exp 8", level); end
    for (int k = 0; k < 8; k++) begin
      cycle('0, '0, 1'b0, 1'b0, 1'b1, '0);
      checks++; if (dout_vld !== 1'b1) begin errors++; $display("FAIL sc_vld[%0d] got %b exp 1", k, dout_vld); end
      checks++; if (dout[FPAY-1:0] !== FPAY'(32'hA0 + k)) begin errors++; $display("FAIL sc_pay[%0d] got %h exp %h", k, dout[FPAY-1:0], 32'hA0 + k); end
      checks++; if (dout[FPAY +: CHW_L] !== CHW_L'(2)) begin errors++; $display("FAIL sc_ch[%0d] got %0d exp 2", k, dout[FPAY +: CHW_L]); end
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL sc_dout[%0d] got %h exp %h", k, dout, m_dout); end
    end
    idle(1);
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL sc_vld_pulse got %b exp 0", dout_vld); end
  endtask

  task automatic test_wrap();
    logic [CHN*FPAY-1:0] d;
    cycle('0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 40; k++) begin
      d = '0; d[FPAY-1:0] = FPAY'(k);
      cycle(4'b0001, d, 1'b0, 1'b0, 1'b0, '0);
    end
    cycle('0, '0, 1'b0, 1'b1, 1'b0, 5'd4);
    for (int k = 40; k < 44; k++) begin
      d = '0; d[FPAY-1:0] = FPAY'(k);
      cycle(4'b0001, d, 1'b0, 1'b0, 1'b0, '0);
    end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL wrap_level got %0d exp 16", level); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL wrap_state got %0d exp 3", state); end
    for (int k = 0; k < 16; k++) begin
      cycle('0, '0, 1'b0, 1'b0, 1'b1, '0);
      checks++; if (dout[FPAY-1:0] !== FPAY'(28 + k)) begin errors++; $display("FAIL wrap_pay[%0d] got %0d exp %0d", k, dout[FPAY-1:0], 28 + k); end
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL wrap_dout[%0d] got %h exp %h", k, dout, m_dout); end
    end
    checks++; if (level !== '0) begin errors++; $display("FAIL wrap_drained got %0d exp 0", level); end
  endtask

  task automatic test_arbitration();
    logic [CHN*FPAY-1:0] d;
    int start, c;
    cycle('0, '0, 1'b1, 1'b0, 1'b0, '0);
    start = (m_last + 1) % CHN;
    for (int k = 0; k < 10; k++) begin
      for (int ch = 0; ch < CHN; ch++) d[ch*FPAY +: FPAY] = FPAY'(ch * 256 + k);
      cycle(4'b1111, d, 1'b0, 1'b0, 1'b0, '0);
    end
    checks++; if (drop_cnt !== 8'd30) begin errors++; $display("FAIL arb_drop30 got %0d exp 30", drop_cnt); end
    cycle('0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      cycle('0, '0, 1'b0, 1'b0, 1'b1, '0);
      c = (start + k) % CHN;
      checks++; if (dout[FPAY +: CHW_L] !== CHW_L'(c)) begin errors++; $display("FAIL arb_ch[%0d] got %0d exp %0d", k, dout[FPAY +: CHW_L], c); end
      checks++; if (dout[FPAY-1:0] !== FPAY'(c * 256 + k)) begin errors++; $display("FAIL arb_pay[%0d] got %h exp %h", k, dout[FPAY-1:0], c * 256 + k); end
    end
    cycle('0, '0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL arb_drop_clr got %0d exp 0", drop_cnt); end
    for (int k = 0; k < 100; k++) cycle(4'b1111, {CHN*FPAY{1'b1}}, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL arb_drop_sat got %0d exp 255", drop_cnt); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL arb_level got %0d exp 16", level); end
  endtask

  task automatic test_post_zero();
    cycle('0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) cycle(4'b0010, {CHN*FPAY{1'b0}}, 1'b0, 1'b0, 1'b0, '0);
    cycle('0, '0, 1'b0, 1'b1, 1'b0, 5'd0);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL pz_state got %0d exp 3", state); end
    for (int k = 0; k < 3; k++) cycle(4'b1111, '0, 1'b0, 1'b1, 1'b0, 5'd5);
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL pz_level got %0d exp 3", level); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL pz_drop got %0d exp 0", drop_cnt); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL pz_hold got %0d exp 3", state); end
    cycle('0, '0, 1'b1, 1'b1, 1'b1, 5'd0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL pz_rearm got %0d exp 1", state); end
    checks++; if (trig_seen !== 1'b0) begin errors++; $display("FAIL pz_trig got %b exp 0", trig_seen); end
    checks++; if (level !== '0) begin errors++; $display("FAIL pz_lvl0 got %0d exp 0", level); end
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL pz_vld got %b exp 0", dout_vld); end
  endtask

  task automatic test_empty_read();
    logic [CHN*FPAY-1:0] d;
    int ts_exp[3];
    ts_exp[0] = 5; ts_exp[1] = 6; ts_exp[2] = 9;
    apply_reset();
    d = '0; d[3*FPAY +: FPAY] = 32'h5A5A_0001;
    cycle('0, '0, 1'b1, 1'b0, 1'b0, '0);      // ts 0
    idle(4);                                  // ts 1..4
    cycle(4'b1000, d, 1'b0, 1'b0, 1'b0, '0);  // ts 5
    cycle(4'b1000, d, 1'b0, 1'b0, 1'b0, '0);  // ts 6
    idle(2);                                  // ts 7..8
    cycle(4'b1000, d, 1'b0, 1'b0, 1'b0, '0);  // ts 9
    cycle('0, '0, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      cycle('0, '0, 1'b0, 1'b0, 1'b1, '0);
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL er_dout[%0d] got %h exp %h", k, dout, m_dout); end
`ifdef TB_TIMESTAMP_EN
      checks++; if (dout[TBW-1 -: TSW] !== TSW'(ts_exp[k])) begin errors++; $display("FAIL er_ts[%0d] got %0d exp %0d", k, dout[TBW-1 -: TSW], ts_exp[k]); end
`else
      checks++; if (dout[FPAY +: CHW_L] !== CHW_L'(3)) begin errors++; $display("FAIL er_ch[%0d] got %0d exp 3 (ts %0d)", k, dout[FPAY +: CHW_L], ts_exp[k]); end
`endif
    end
    for (int k = 0; k < 2; k++) begin
      cycle('0, '0, 1'b0, 1'b0, 1'b1, '0);
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL er_empty_vld got %b exp 0", dout_vld); end
      checks++; if (level !== '0) begin errors++; $display("FAIL er_empty_lvl got %0d exp 0", level); end
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL er_empty_state got %0d exp 3", state); end
    end
  endtask

  task automatic test_random();
    logic [CHN*FPAY-1:0] d;
    logic [CHN-1:0] v;
    logic a, t, r;
    logic [AW:0] pl;
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < CHN; ch++) d[ch*FPAY +: FPAY] = $urandom;
      v  = CHN'($urandom_range(0, (1 << CHN) - 1));
      t  = ($urandom_range(0, 19) == 0);
      r  = $urandom_range(0, 1) == 1;
      pl = (AW + 1)'($urandom_range(0, 31));
      a  = ($urandom_range(0, 79) == 0) || (m_state == 0) ||
           ((m_state == 3) && (mq.size() == 0) && ($urandom_range(0, 3) == 0));
      cycle(v, d, a, t, r, pl);
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d] got %0d exp %0d", i, state, m_state); end
      checks++; if (level !== 5'(mq.size())) begin errors++; $display("FAIL rnd_level[%0d] got %0d exp %0d", i, level, mq.size()); end
      checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop[%0d] got %0d exp %0d", i, drop_cnt, m_drop); end
      checks++; if (trig_seen !== m_trig) begin errors++; $display("FAIL rnd_trig[%0d] got %b exp %b", i, trig_seen, m_trig); end
      checks++; if (dout_vld !== m_vld) begin errors++; $display("FAIL rnd_vld[%0d] got %b exp %b", i, dout_vld, m_vld); end
      if (m_vld) begin
        checks++; if (dout !== m_dout) begin errors++; $display("FAIL rnd_dout[%0d] got %h exp %h", i, dout, m_dout); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_wrap();
    test_arbitration();
    test_post_zero();
    test_random();
    test_empty_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
